// File: rtl/kbd_pkg.sv
// Shared constants, key-vector type and counter sizing helper for the keyboard debouncer.
package kbd_pkg;

  localparam int KBD_N_KEYS           = 6;
  localparam int KBD_DEBOUNCE_DEFAULT = 50000;

  typedef logic [KBD_N_KEYS-1:0] kbd_keys_t;

  // ceil(log2(cycles)) + 1; one spare bit keeps the terminal compare unambiguous.
  function automatic int kbd_cnt_width(input int cycles);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < cycles) w = i + 1;
    end
    return w + 1;
  endfunction

endpackage

// File: rtl/kbd_debounce_ch.sv
// One key channel: 2-flop synchroniser, persistence counter, accepted level and edge pulses.
// Input is already polarity-normalised (1 = pressed).
module kbd_debounce_ch
  import kbd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KBD_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam int            CW       = kbd_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_d, sync1_q;
  logic          sync2_d, sync2_q;
  logic          stable_d, stable_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          press_d, press_q;
  logic          release_d, release_q;

  // Any sample matching the accepted level clears the count: no partial credit.
  always_comb begin
    sync1_d   = key_in;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d  = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state   = stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/keyboard_debouncer.sv
// Front-panel key conditioner: polarity normalisation, per-key debounce, press/release pulses.
// Optional sticky press flags and interrupt when KBD_EVENT_LATCH_EN is defined.
module keyboard_debouncer
  import kbd_pkg::*;
#(
  parameter int N_KEYS          = KBD_N_KEYS,
  parameter int DEBOUNCE_CYCLES = KBD_DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
`ifdef KBD_EVENT_LATCH_EN
  ,
  input  logic [N_KEYS-1:0] event_clr,
  output logic [N_KEYS-1:0] key_event,
  output logic              key_irq
`endif
);

  logic [N_KEYS-1:0] key_norm;

  assign key_norm = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    kbd_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_in     (key_norm[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

`ifdef KBD_EVENT_LATCH_EN
  logic [N_KEYS-1:0] event_d, event_q;
  logic              irq_d, irq_q;

  // Set has priority over a same-cycle clear so a press is never lost.
  always_comb begin
    event_d = (event_q & ~event_clr) | key_press;
    irq_d   = |event_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= event_d;
      irq_q   <= irq_d;
    end
  end

  assign key_event = event_q;
  assign key_irq   = irq_q;
`endif

endmodule

// File: tb/tb_keyboard_debouncer.sv
// Self-checking bench for keyboard_debouncer (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
module tb_keyboard_debouncer;

  localparam int D = 4;

  logic       clk;
  logic       reset_n;
  logic [5:0] key_raw;
  logic [5:0] key_state, key_press, key_release;
`ifdef KBD_EVENT_LATCH_EN
  logic [5:0] event_clr;
  logic [5:0] key_event;
  logic       key_irq;
`endif

  int n_pass;
  int n_total;

  keyboard_debouncer #(
    .N_KEYS(6),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
`ifdef KBD_EVENT_LATCH_EN
    ,
    .event_clr  (event_clr),
    .key_event  (key_event),
    .key_irq    (key_irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a key's accepted level flips once the synchronised level
  // (raw sample from two edges back) has differed from it for D edges in a row.
  logic [5:0] hist [0:D];
  logic [5:0] m_state, m_press, m_release, m_acc;
`ifdef KBD_EVENT_LATCH_EN
  logic [5:0] m_event;
  logic       m_irq;
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= D; i++) hist[i] = '0;
      m_state   = '0;
      m_press   = '0;
      m_release = '0;
`ifdef KBD_EVENT_LATCH_EN
      m_event   = '0;
      m_irq     = 1'b0;
`endif
    end else begin
      for (int b = 0; b < 6; b++) begin
        m_acc[b] = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (hist[1+j][b] == m_state[b]) m_acc[b] = 1'b0;
        end
      end
`ifdef KBD_EVENT_LATCH_EN
      m_event = (m_event & ~event_clr) | m_press;
      m_irq   = |m_event;
`endif
      m_press   = m_acc & ~m_state;
      m_release = m_acc & m_state;
      m_state   = m_state ^ m_acc;
      for (int i = D; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ~key_raw;
    end
  end

`ifdef KBD_EVENT_LATCH_EN
  logic [24:0] dut_vec, mdl_vec;
  assign dut_vec = {key_state, key_press, key_release, key_event, key_irq};
  assign mdl_vec = {m_state, m_press, m_release, m_event, m_irq};
`else
  logic [17:0] dut_vec, mdl_vec;
  assign dut_vec = {key_state, key_press, key_release};
  assign mdl_vec = {m_state, m_press, m_release};
`endif

  task automatic test_reset();
    reset_n = 1'b0;
    key_raw = 6'h3F;
`ifdef KBD_EVENT_LATCH_EN
    event_clr = '0;
`endif
    repeat (3) @(negedge clk);
    n_total++;
    if (dut_vec !== '0) $display("FAIL reset_hold got=%h want=0", dut_vec);
    else n_pass++;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== '0) $display("FAIL reset_idle cyc=%0d got=%h want=0", i, dut_vec);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    @(negedge clk);
    key_raw[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL press_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
      if (i == 5) begin
        n_total++;
        if (key_state[0] !== 1'b0) $display("FAIL press_early got=%b want=0", key_state[0]);
        else n_pass++;
      end
      if (i == 6) begin
        n_total++;
        if ({key_state[0], key_press[0]} !== 2'b11)
          $display("FAIL press_edge got=%b want=11", {key_state[0], key_press[0]});
        else n_pass++;
      end
      if (i == 7) begin
        n_total++;
        if (key_press[0] !== 1'b0) $display("FAIL press_width got=%b want=0", key_press[0]);
        else n_pass++;
      end
    end
    key_raw[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL press_rel_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    int presses;
    pat = 16'b0000_0000_1000_1000;
    presses = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL bounce_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
      if (key_press[2] === 1'b1) presses++;
      if (i < 12) begin
        n_total++;
        if (key_state[2] !== 1'b0) $display("FAIL bounce_reject cyc=%0d got=%b want=0", i, key_state[2]);
        else n_pass++;
      end
      key_raw[2] = (i < 16) ? pat[i] : 1'b0;
    end
    n_total++;
    if (presses != 1 || key_state[2] !== 1'b1)
      $display("FAIL bounce_accept presses=%0d state=%b want presses=1 state=1", presses, key_state[2]);
    else n_pass++;
    key_raw[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL bounce_rel_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    int rel_cycles;
    key_raw = 6'h00;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL simul_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
      if (i == 6) begin
        n_total++;
        if ({key_state, key_press} !== 12'hFFF)
          $display("FAIL simul_press state=%h press=%h want 3f/3f", key_state, key_press);
        else n_pass++;
      end
    end
    key_raw = 6'h3F;
    rel_cycles = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL simul_rel_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
      if (key_release == 6'h3F) rel_cycles++;
      else if (key_release != 6'h00) rel_cycles += 100;
    end
    n_total++;
    if (rel_cycles != 1 || key_state !== 6'h00)
      $display("FAIL simul_release count=%0d state=%h want count=1 state=0", rel_cycles, key_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    key_raw[5] = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (dut_vec !== '0) $display("FAIL midrst_hold got=%h want=0", dut_vec);
    else n_pass++;
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL midrst_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
      if (i == 5) begin
        n_total++;
        if ({key_state[5], key_press[5]} !== 2'b00)
          $display("FAIL midrst_early got=%b want=00", {key_state[5], key_press[5]});
        else n_pass++;
      end
      if (i == 6) begin
        n_total++;
        if ({key_state[5], key_press[5]} !== 2'b11)
          $display("FAIL midrst_edge got=%b want=11", {key_state[5], key_press[5]});
        else n_pass++;
      end
    end
    key_raw[5] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL midrst_rel_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL random_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
      n_total++;
      if ((key_press & key_release) !== 6'h00)
        $display("FAIL random_exclusive press=%h release=%h want no overlap", key_press, key_release);
      else n_pass++;
      for (int b = 0; b < 6; b++) begin
        if ($urandom_range(5, 0) == 0) key_raw[b] = ~key_raw[b];
      end
`ifdef KBD_EVENT_LATCH_EN
      event_clr = ($urandom_range(7, 0) == 0) ? 6'($urandom) : 6'h00;
`endif
    end
    key_raw = 6'h3F;
`ifdef KBD_EVENT_LATCH_EN
    event_clr = 6'h3F;
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL random_settle cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
    end
`ifdef KBD_EVENT_LATCH_EN
    event_clr = 6'h00;
`endif
  endtask

`ifdef KBD_EVENT_LATCH_EN
  task automatic test_event();
    bit seen;
    key_raw[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (key_press[2] === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL event_press_timeout got=0 want=1");
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({key_event, key_irq} !== {6'h04, 1'b1})
      $display("FAIL event_set event=%h irq=%b want 04/1", key_event, key_irq);
    else n_pass++;
    key_raw[2] = 1'b1;
    repeat (8) @(negedge clk);
    key_raw[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL event_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
      if (key_press[2] === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL event_repress_timeout got=0 want=1");
    else n_pass++;
    event_clr = 6'h04;
    @(negedge clk);
    event_clr = 6'h00;
    n_total++;
    if ({key_event, key_irq} !== {6'h04, 1'b1})
      $display("FAIL event_set_wins event=%h irq=%b want 04/1", key_event, key_irq);
    else n_pass++;
    repeat (3) @(negedge clk);
    event_clr = 6'h04;
    @(negedge clk);
    event_clr = 6'h00;
    n_total++;
    if ({key_event, key_irq} !== {6'h00, 1'b0})
      $display("FAIL event_clear event=%h irq=%b want 00/0", key_event, key_irq);
    else n_pass++;
    key_raw[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL event_rel_model cyc=%0d got=%h want=%h", i, dut_vec, mdl_vec);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
`ifdef KBD_EVENT_LATCH_EN
    test_event();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keyboard_debouncer.md
Name: keyboard_debouncer

Overview:
- Conditions the six raw front-panel keys SW1..SW6 before they reach the CPU.
- Per key: synchronises, debounces and normalises polarity of the raw input.
- Drives the clean 6-bit level straight into the in_port of the SW6..SW1 keyboard PIO, one stage upstream of the Avalon read path.
- Also emits one-cycle press/release pulses for local logic.

Parameters:
- N_KEYS, 6: number of key channels; bit 0 = SW1.
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles a new level must persist before it is accepted (1 ms at 50 MHz); legal range 1..2^20.
- ACTIVE_LOW, 1: 1 = raw key reads 0 when pressed; 0 = raw key reads 1 when pressed.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- key_raw  input  N_KEYS  raw asynchronous key pins.
- key_state  output  N_KEYS  debounced level, 1 = pressed; feeds the PIO in_port.
- key_press  output  N_KEYS  one-cycle pulse on released->pressed.
- key_release  output  N_KEYS  one-cycle pulse on pressed->released.

Behaviour:
- Interface: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Polarity: raw is inverted when ACTIVE_LOW=1. Pressed=1 internally and at all outputs.
- Synchroniser: 2-flop chain per key (sync1, sync2). Reset value = released level.
- Counter per key, width ceil(log2(DEBOUNCE_CYCLES))+1 bits.
  - Every edge where sync2 == stable: cnt <= 0.
  - Every edge where sync2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Every edge where sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
- Glitch rejection: any return to the stable value before acceptance clears cnt. There is no partial credit.
- Latency: raw change sampled into sync1 at edge k -> stable/key_state updates at edge k+1+DEBOUNCE_CYCLES.
- key_state: registered, driven directly from stable.
- key_press / key_release: registered, asserted for exactly the one cycle following the stable update edge. Never both high on the same bit.
- Channels are fully independent. Simultaneous transitions on several keys produce simultaneous pulses.
- Counter wrap: impossible, because cnt saturates at DEBOUNCE_CYCLES-1 before clearing.
- Reset values: all outputs 0; stable=0 (released); cnt=0; sync chain = released level.
- Reset asserted mid-count: the pending transition is discarded; no pulse is generated on release of reset.
- Key held pressed through reset: after reset deassert it is accepted like any new press, with full latency and a key_press pulse.

Optional Feature:
- Macro: KBD_EVENT_LATCH_EN.
- When defined, adds ports:
  - event_clr  input  N_KEYS: write-one-to-clear mask.
  - key_event  output  N_KEYS: sticky press flags.
  - key_irq  output  1: OR of key_event.
- key_event bit sets on key_press and holds until event_clr on that bit. Set and clear in the same cycle: set wins.
- key_event and key_irq are registered; both reset to 0.
- When the macro is undefined: those ports and registers do not exist, and the remaining behaviour is identical.

Decomposition:
- Package kbd_pkg:
  - constant KBD_N_KEYS=6
  - constant KBD_DEBOUNCE_DEFAULT=50000
  - function kbd_cnt_width(cycles)
  - typedef kbd_keys_t = logic [KBD_N_KEYS-1:0]
- Sub-module kbd_debounce_ch: single channel (sync, counter, stable, edge pulses), generate-instantiated N_KEYS times.
- The top level holds the polarity inversion and the optional event latch.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
- Reset: reset_n=0 with key_raw=6'h3F, release reset -> key_state=0, all pulses 0, and no pulse for 20 cycles.
- Clean press: key_raw[0] 1->0 sampled at edge 10 -> key_state[0]=1 after edge 15; key_press[0]=1 for exactly the cycle after edge 15.
- Bounce: key_raw[2] low 3 cycles, high 1 cycle, low 3 cycles -> no change. After a steady 4-cycle low, key_state[2]=1 with a single press pulse.
- Simultaneous: key_raw 6'h3F->6'h00 at one edge -> key_state=6'h3F and key_press=6'h3F in the same cycle. Return to 6'h3F -> key_release=6'h3F once.
- Reset mid-count: key_raw[5] low for 2 cycles, reset pulse, key_raw[5] remains low -> key_state[5] rises exactly 5 cycles after the first post-reset sample edge, with one press pulse.
- KBD_EVENT_LATCH_EN: press SW3 -> key_event=6'h04, key_irq=1. event_clr=6'h04 in the same cycle as a new SW3 press -> key_event stays 6'h04. A later event_clr alone -> key_event=0, key_irq=0.
